// File: rtl/riscv_i32_trace_pack_pkg.sv
// Shared types for the RISC-V i32 trace packer: packet types, header layout,
// the trace bus payload struct and the header packing helper.
package riscv_i32_trace_pack_types;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned DROP_W  = 16;
    localparam int unsigned MODE_W  = 3;
    localparam int unsigned RSN_W   = 4;

    typedef enum logic [3:0] {
        PKT_SYNC   = 4'd0,
        PKT_SEQ    = 4'd1,
        PKT_BRANCH = 4'd2,
        PKT_BKPT   = 4'd3
    } pkt_type_e;

    localparam int unsigned HDR_TYPE_LSB = 28;
    localparam int unsigned HDR_CNT_LSB  = 20;
    localparam int unsigned HDR_MODE_LSB = 17;
    localparam int unsigned HDR_TRAP_BIT = 16;
    localparam int unsigned HDR_RET_BIT  = 15;
    localparam int unsigned HDR_JALR_BIT = 14;
    localparam int unsigned HDR_RSN_LSB  = 10;

    localparam logic [CNT_W-1:0] SEQ_SAT    = 8'd255;
    localparam logic [CNT_W-1:0] SEQ_SAT_M1 = 8'd254;

    typedef struct packed {
        logic                instr_valid;
        logic [MODE_W-1:0]   mode;
        logic [WORD_W-1:0]   instr_pc;
        logic                branch_taken;
        logic [WORD_W-1:0]   branch_target;
        logic                trap;
        logic                ret;
        logic                jalr;
        logic                bkpt_valid;
        logic [RSN_W-1:0]    bkpt_reason;
    } trace_bus_t;

    function automatic logic [WORD_W-1:0] pack_hdr(
        input pkt_type_e         typ,
        input logic [CNT_W-1:0]  cnt,
        input logic [MODE_W-1:0] mode,
        input logic              trap,
        input logic              ret,
        input logic              jalr,
        input logic [RSN_W-1:0]  rsn
    );
        logic [WORD_W-1:0] h;
        h = '0;
        h[HDR_TYPE_LSB +: 4]      = typ;
        h[HDR_CNT_LSB +: CNT_W]   = cnt;
        h[HDR_MODE_LSB +: MODE_W] = mode;
        h[HDR_TRAP_BIT]           = trap;
        h[HDR_RET_BIT]            = ret;
        h[HDR_JALR_BIT]           = jalr;
        h[HDR_RSN_LSB +: RSN_W]   = rsn;
        return h;
    endfunction

endpackage

// File: rtl/riscv_i32_trace_pack_fifo.sv
// Packet FIFO with two write ports (a whole record lands in one cycle) and one
// read port; level is one bit wider than the pointers to tell full from empty.
module riscv_i32_trace_pack_fifo #(
    parameter int unsigned FIFO_LOG2 = 4,
    parameter int unsigned WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [1:0]        wr_cnt_i,
    input  logic [WORD_W-1:0] wr_data0_i,
    input  logic [WORD_W-1:0] wr_data1_i,
    input  logic              rd_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              valid_o,
    output logic [FIFO_LOG2:0] level_o
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned LVL_W = FIFO_LOG2 + 1;

    logic [WORD_W-1:0]    mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 push0, push1, pop;

    always_comb begin
        push0    = en_i && (wr_cnt_i != 2'd0);
        push1    = en_i && (wr_cnt_i == 2'd2);
        pop      = en_i && rd_i;
        wr_ptr_d = push0 ? wr_ptr_q + FIFO_LOG2'(wr_cnt_i) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + FIFO_LOG2'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push0) + LVL_W'(push1) - LVL_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push0) mem_q[wr_ptr_q] <= wr_data0_i;
        if (push1) mem_q[wr_ptr_q + FIFO_LOG2'(1)] <= wr_data1_i;
    end

    always_ff @(posedge clk) begin
        if (rst_n && en_i) begin
            assert (LVL_W'(wr_cnt_i) <= LVL_W'(DEPTH) - level_q + LVL_W'(rd_i));
            assert (!rd_i || (level_q != '0));
        end
    end

    assign valid_o   = (level_q != '0);
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o   = level_q;

endmodule

// File: rtl/riscv_i32_trace_pack.sv
// Compresses retired-instruction trace into 32-bit packets: sequential runs are
// counted, only discontinuities, breakpoints and sync points carry addresses.
module riscv_i32_trace_pack
    import riscv_i32_trace_pack_types::*;
#(
    parameter int unsigned FIFO_LOG2 = 4
) (
    input  logic               clk,
    input  logic               clk__enable,
    input  logic               reset_n,
    input  logic               riscv_clk_enable,
    input  logic               trace_enable,
    input  logic               flush,
    input  logic               trace__instr_valid,
    input  logic [2:0]         trace__mode,
    input  logic [31:0]        trace__instr_pc,
    input  logic [31:0]        trace__instruction,
    input  logic               trace__branch_taken,
    input  logic [31:0]        trace__branch_target,
    input  logic               trace__trap,
    input  logic               trace__ret,
    input  logic               trace__jalr,
    input  logic               trace__rfw_retire,
    input  logic               trace__rfw_data_valid,
    input  logic [4:0]         trace__rfw_rd,
    input  logic [31:0]        trace__rfw_data,
    input  logic               trace__bkpt_valid,
    input  logic [3:0]         trace__bkpt_reason,
    output logic               pkt_valid,
    output logic [31:0]        pkt_data,
    input  logic               pkt_ready,
    output logic [FIFO_LOG2:0] fifo_level,
    output logic               overflow_sticky
);

    localparam int unsigned     LVL_W = FIFO_LOG2 + 1;
    localparam logic [LVL_W-1:0] DEPTH = LVL_W'(1 << FIFO_LOG2);

    trace_bus_t         bus;
    logic               sample, pop, seq_inc, rec_sync;
    logic [1:0]         rec_words, wr_cnt;
    logic [WORD_W-1:0]  rec_hdr, rec_w1;
    logic [LVL_W-1:0]   free;
    logic [CNT_W-1:0]   flush_cnt;
    logic [CNT_W-1:0]   seq_count_q, seq_count_d;
    logic [DROP_W-1:0]  drop_count_q, drop_count_d;
    logic               sync_pending_q, sync_pending_d;
    logic               overflow_q, overflow_d;
    logic               trace_en_q, trace_en_d;
    logic               unused_bus;

    assign bus = '{instr_valid: trace__instr_valid, mode: trace__mode,
                   instr_pc: trace__instr_pc, branch_taken: trace__branch_taken,
                   branch_target: trace__branch_target, trap: trace__trap,
                   ret: trace__ret, jalr: trace__jalr,
                   bkpt_valid: trace__bkpt_valid, bkpt_reason: trace__bkpt_reason};

    assign unused_bus = ^{trace__instruction, trace__rfw_retire, trace__rfw_data_valid,
                          trace__rfw_rd, trace__rfw_data};

    always_comb begin
        rec_words      = 2'd0;
        rec_hdr        = '0;
        rec_w1         = '0;
        rec_sync       = 1'b0;
        seq_inc        = 1'b0;
        wr_cnt         = 2'd0;
        drop_count_d   = drop_count_q;
        sync_pending_d = sync_pending_q;
        overflow_d     = overflow_q;
        trace_en_d     = clk__enable ? trace_enable : trace_en_q;

        sample = clk__enable && riscv_clk_enable && trace_enable && bus.instr_valid;
        pop    = clk__enable && pkt_valid && pkt_ready;
        free   = DEPTH - fifo_level + LVL_W'(pop);

        // Record selection, highest priority first.
        if (sample) begin
            if (sync_pending_q) begin
                rec_words = 2'd2;
                rec_sync  = 1'b1;
                rec_hdr   = pack_hdr(PKT_SYNC, seq_count_q, bus.mode, 1'b0, 1'b0, 1'b0, '0)
                          | WORD_W'(drop_count_q);
                rec_w1    = bus.instr_pc;
            end else if (bus.bkpt_valid) begin
                rec_words = 2'd2;
                rec_hdr   = pack_hdr(PKT_BKPT, seq_count_q, bus.mode, bus.trap, bus.ret,
                                     bus.jalr, bus.bkpt_reason);
                rec_w1    = bus.instr_pc;
            end else if (bus.branch_taken || bus.trap || bus.ret) begin
                rec_words = 2'd2;
                rec_hdr   = pack_hdr(PKT_BRANCH, seq_count_q, bus.mode, bus.trap, bus.ret,
                                     bus.jalr, '0);
                rec_w1    = bus.branch_target;
            end else if (seq_count_q == SEQ_SAT_M1) begin
                rec_words = 2'd1;
                rec_hdr   = pack_hdr(PKT_SEQ, SEQ_SAT, bus.mode, 1'b0, 1'b0, 1'b0, '0);
            end else begin
                seq_inc = 1'b1;
            end
        end

        // A flush that meets a record is absorbed: the record carries the count.
        flush_cnt = seq_inc ? seq_count_q + 8'd1 : seq_count_q;
        if (clk__enable && flush && (rec_words == 2'd0) && (flush_cnt != '0)) begin
            rec_words = 2'd1;
            rec_hdr   = pack_hdr(PKT_SEQ, flush_cnt, bus.mode, 1'b0, 1'b0, 1'b0, '0);
        end

        seq_count_d = seq_inc ? seq_count_q + 8'd1 : seq_count_q;
        if (rec_words != 2'd0) begin
            seq_count_d = '0;
            if (free >= LVL_W'(rec_words)) begin
                wr_cnt = rec_words;
                if (rec_sync) begin
                    drop_count_d   = '0;
                    sync_pending_d = 1'b0;
                end
            end else begin
                drop_count_d   = (drop_count_q == '1) ? drop_count_q : drop_count_q + 16'd1;
                overflow_d     = 1'b1;
                sync_pending_d = 1'b1;
            end
        end

        if (clk__enable && trace_en_q && !trace_enable) sync_pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_count_q    <= '0;
            drop_count_q   <= '0;
            sync_pending_q <= 1'b1;
            overflow_q     <= 1'b0;
            trace_en_q     <= 1'b0;
        end else begin
            seq_count_q    <= seq_count_d;
            drop_count_q   <= drop_count_d;
            sync_pending_q <= sync_pending_d;
            overflow_q     <= overflow_d;
            trace_en_q     <= trace_en_d;
        end
    end

    assign overflow_sticky = overflow_q;

    riscv_i32_trace_pack_fifo #(
        .FIFO_LOG2 (FIFO_LOG2),
        .WORD_W    (WORD_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .en_i       (clk__enable),
        .wr_cnt_i   (wr_cnt),
        .wr_data0_i (rec_hdr),
        .wr_data1_i (rec_w1),
        .rd_i       (pop),
        .rd_data_o  (pkt_data),
        .valid_o    (pkt_valid),
        .level_o    (fifo_level)
    );

endmodule

// File: tb/tb_riscv_i32_trace_pack.sv
// Scoreboard bench for riscv_i32_trace_pack: expected words are queued as trace
// is driven and compared as the packet stream is consumed.
`timescale 1ns/1ps
module tb_riscv_i32_trace_pack;

    localparam int unsigned FIFO_LOG2 = 4;

    logic        clk = 1'b0;
    logic        clk__enable, reset_n, riscv_clk_enable, trace_enable, flush;
    logic        trace__instr_valid, trace__branch_taken, trace__trap, trace__ret, trace__jalr;
    logic [2:0]  trace__mode;
    logic [31:0] trace__instr_pc, trace__instruction, trace__branch_target, trace__rfw_data;
    logic        trace__rfw_retire, trace__rfw_data_valid, trace__bkpt_valid;
    logic [4:0]  trace__rfw_rd;
    logic [3:0]  trace__bkpt_reason;
    logic        pkt_valid, pkt_ready, overflow_sticky;
    logic [31:0] pkt_data;
    logic [FIFO_LOG2:0] fifo_level;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    riscv_i32_trace_pack #(.FIFO_LOG2(FIFO_LOG2)) dut (
        .clk                   (clk),
        .clk__enable           (clk__enable),
        .reset_n               (reset_n),
        .riscv_clk_enable      (riscv_clk_enable),
        .trace_enable          (trace_enable),
        .flush                 (flush),
        .trace__instr_valid    (trace__instr_valid),
        .trace__mode           (trace__mode),
        .trace__instr_pc       (trace__instr_pc),
        .trace__instruction    (trace__instruction),
        .trace__branch_taken   (trace__branch_taken),
        .trace__branch_target  (trace__branch_target),
        .trace__trap           (trace__trap),
        .trace__ret            (trace__ret),
        .trace__jalr           (trace__jalr),
        .trace__rfw_retire     (trace__rfw_retire),
        .trace__rfw_data_valid (trace__rfw_data_valid),
        .trace__rfw_rd         (trace__rfw_rd),
        .trace__rfw_data       (trace__rfw_data),
        .trace__bkpt_valid     (trace__bkpt_valid),
        .trace__bkpt_reason    (trace__bkpt_reason),
        .pkt_valid             (pkt_valid),
        .pkt_data              (pkt_data),
        .pkt_ready             (pkt_ready),
        .fifo_level            (fifo_level),
        .overflow_sticky       (overflow_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Header for mode 3 with jalr/ret clear.
    function automatic logic [31:0] hdr(input logic [3:0] typ, input logic [7:0] cnt,
                                        input logic trap, input logic [3:0] rsn,
                                        input logic [15:0] drop);
        return {typ, cnt, 3'd3, trap, 1'b0, 1'b0, rsn, 10'd0} | {16'd0, drop};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_instr(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                              input logic trap, input logic bkpt, input logic [3:0] rsn);
        trace__instr_valid   = 1'b1;
        trace__instr_pc      = pc;
        trace__branch_taken  = taken;
        trace__branch_target = tgt;
        trace__trap          = trap;
        trace__bkpt_valid    = bkpt;
        trace__bkpt_reason   = rsn;
        tick();
        trace__instr_valid   = 1'b0;
        trace__branch_taken  = 1'b0;
        trace__trap          = 1'b0;
        trace__bkpt_valid    = 1'b0;
        trace__bkpt_reason   = 4'd0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        tick();
        tick();
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_level"}, 32'(fifo_level), 32'd0);
    endtask

    // Consumer side: a word leaves the FIFO on the next edge when valid && ready.
    always @(negedge clk) begin
        if (reset_n && clk__enable && pkt_valid && pkt_ready) begin
            check_eq("pkt_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("pkt_data", pkt_data, exp_q.pop_front());
        end
    end

    initial begin
        clk__enable = 1'b1; reset_n = 1'b0; riscv_clk_enable = 1'b1; trace_enable = 1'b1;
        flush = 1'b0; pkt_ready = 1'b1;
        trace__instr_valid = 1'b0; trace__mode = 3'd3; trace__instr_pc = '0;
        trace__instruction = '0; trace__branch_taken = 1'b0; trace__branch_target = '0;
        trace__trap = 1'b0; trace__ret = 1'b0; trace__jalr = 1'b0;
        trace__rfw_retire = 1'b0; trace__rfw_data_valid = 1'b0; trace__rfw_rd = '0;
        trace__rfw_data = '0; trace__bkpt_valid = 1'b0; trace__bkpt_reason = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(pkt_valid), 32'd0);
        check_eq("rst_data", pkt_data, 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_ovf", 32'(overflow_sticky), 32'd0);
        reset_n = 1'b1;
        tick();

        // Sync, three sequential, then a taken branch.
        exp_q.push_back(32'h0006_0000); exp_q.push_back(32'h0000_1000);
        send_instr(32'h1000, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) send_instr(32'h1004 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        exp_q.push_back(32'h2036_0000); exp_q.push_back(32'h0000_2000);
        send_instr(32'h1010, 1'b1, 32'h2000, 1'b0, 1'b0, 4'd0);
        wait_drain("t1_drain");

        // 255 sequential saturate into one SEQ word; a 256th is then flushed.
        for (int i = 0; i < 255; i++) begin
            if (i == 254) exp_q.push_back(32'h1FF6_0000);
            send_instr(32'h2000 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        end
        send_instr(32'h2400, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        exp_q.push_back(32'h1016_0000);
        flush_pulse();
        wait_drain("t2_drain");

        // Flush with nothing counted emits nothing.
        flush_pulse();
        tick();
        check_eq("flush_empty_level", 32'(fifo_level), 32'd0);

        // An instruction without riscv_clk_enable is not counted.
        send_instr(32'h2500, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        riscv_clk_enable = 1'b0;
        send_instr(32'h2504, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        riscv_clk_enable = 1'b1;
        send_instr(32'h2508, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        exp_q.push_back(32'h1026_0000);
        flush_pulse();
        wait_drain("rce_drain");

        // Breakpoint outranks a taken branch.
        exp_q.push_back(32'h3006_1400); exp_q.push_back(32'h0000_3000);
        send_instr(32'h3000, 1'b1, 32'hDEAD_0000, 1'b0, 1'b1, 4'd5);
        wait_drain("t3_drain");

        // Fill the FIFO with the consumer stalled, then drop three records.
        pkt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(hdr(4'd2, 8'd0, 1'b0, 4'd0, 16'd0));
            exp_q.push_back(32'h7000 + 32'(4 * i));
            send_instr(32'h3100 + 32'(4 * i), 1'b1, 32'h7000 + 32'(4 * i), 1'b0, 1'b0, 4'd0);
        end
        check_eq("full_level", 32'(fifo_level), 32'd16);
        for (int i = 0; i < 3; i++) send_instr(32'h3200 + 32'(4 * i), 1'b1, 32'h7100, 1'b0, 1'b0, 4'd0);
        check_eq("drop_level", 32'(fifo_level), 32'd16);
        check_eq("drop_ovf", 32'(overflow_sticky), 32'd1);
        pkt_ready = 1'b1;
        wait_drain("t4_drain");
        check_eq("ovf_sticky", 32'(overflow_sticky), 32'd1);
        exp_q.push_back(32'h0006_0003); exp_q.push_back(32'h0000_4000);
        send_instr(32'h4000, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        wait_drain("t4_sync_drain");

        // Full with a pop: free=1 drops a 2-word record; free=2 accepts it.
        pkt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(hdr(4'd2, 8'd0, 1'b0, 4'd0, 16'd0));
            exp_q.push_back(32'h7200 + 32'(4 * i));
            send_instr(32'h4010 + 32'(4 * i), 1'b1, 32'h7200 + 32'(4 * i), 1'b0, 1'b0, 4'd0);
        end
        check_eq("t5_full_level", 32'(fifo_level), 32'd16);
        pkt_ready = 1'b1;
        send_instr(32'h40F0, 1'b1, 32'h7300, 1'b0, 1'b0, 4'd0);
        pkt_ready = 1'b0;
        check_eq("free1_level", 32'(fifo_level), 32'd15);
        pkt_ready = 1'b1;
        exp_q.push_back(hdr(4'd0, 8'd0, 1'b0, 4'd0, 16'd1)); exp_q.push_back(32'h0000_4100);
        send_instr(32'h4100, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        pkt_ready = 1'b0;
        check_eq("free2_level", 32'(fifo_level), 32'd16);
        pkt_ready = 1'b1;
        wait_drain("t5_drain");

        // Asynchronous reset with seven words queued.
        pkt_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_instr(32'h4200 + 32'(4 * i), 1'b1, 32'h7400, 1'b0, 1'b0, 4'd0);
        send_instr(32'h4210, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        flush_pulse();
        check_eq("pre_rst_level", 32'(fifo_level), 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(pkt_valid), 32'd0);
        check_eq("async_rst_level", 32'(fifo_level), 32'd0);
        check_eq("async_rst_ovf", 32'(overflow_sticky), 32'd0);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        pkt_ready = 1'b1;
        exp_q.push_back(32'h0006_0000); exp_q.push_back(32'h0000_5000);
        send_instr(32'h5000, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        wait_drain("t6_drain");

        // Falling trace_enable forces a sync that still carries the pending count.
        send_instr(32'h5004, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        trace_enable = 1'b0;
        tick();
        trace_enable = 1'b1;
        exp_q.push_back(32'h0016_0000); exp_q.push_back(32'h0000_6000);
        send_instr(32'h6000, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        exp_q.push_back(32'h2007_0000); exp_q.push_back(32'h0000_0100);
        send_instr(32'h6004, 1'b0, 32'h100, 1'b1, 1'b0, 4'd0);
        wait_drain("t7_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_i32_trace_pack.md
Name: riscv_i32_trace_pack

Overview:
- Consumes the RISC-V i32 trace bus alongside the trace sink.
- Compresses retired-instruction trace into 32-bit packets and buffers them in a FIFO.
- Presents packets on a valid/ready stream to the debug transport.
- Sequential instructions are run-length counted; only discontinuities, breakpoints and sync points carry addresses.

Parameters:
FIFO_LOG2  4  log2 of packet FIFO depth in 32-bit words (depth 16); minimum 2

Ports:
clk  input  1  free-running clock
clk__enable  input  1  clock enable; all state advances only when high
reset_n  input  1  asynchronous active-low reset
riscv_clk_enable  input  1  trace bus is sampled only on edges where this is high
trace_enable  input  1  packing enabled; low means no records are generated
flush  input  1  pulse: emit a pending sequential count
trace__instr_valid, trace__mode[2:0], trace__instr_pc[31:0], trace__instruction[31:0], trace__branch_taken, trace__branch_target[31:0], trace__trap, trace__ret, trace__jalr, trace__rfw_retire, trace__rfw_data_valid, trace__rfw_rd[4:0], trace__rfw_data[31:0], trace__bkpt_valid, trace__bkpt_reason[3:0]  input  -  trace bus; rfw_* and instruction fields are unused
pkt_valid  output  1  FIFO non-empty
pkt_data  output  32  FIFO head word
pkt_ready  input  1  consumer pops the head when valid&&ready
fifo_level  output  FIFO_LOG2+1  words held
overflow_sticky  output  1  set on any dropped record; cleared only by reset

Behaviour:
- Reset values: FIFO empty, pkt_valid=0, pkt_data=0, fifo_level=0, overflow_sticky=0, seq_count=0, drop_count=0, sync_pending=1.
- Sample condition: S = clk__enable && riscv_clk_enable && trace_enable && trace__instr_valid.
- Pops use clk__enable only; they are independent of riscv_clk_enable.
- Record selection on S (one record per cycle, this priority):
  - SYNC if sync_pending.
  - BKPT if bkpt_valid.
  - BRANCH if branch_taken || trap || ret.
  - Otherwise sequential.
- Header word fields:
  - [31:28] type: 0=SYNC, 1=SEQ, 2=BRANCH, 3=BKPT.
  - [27:20] seq_count preceding this record.
  - [19:17] mode.
  - [16] trap, [15] ret, [14] jalr.
  - [13:10] bkpt_reason (zero in non-BKPT records).
  - [9:0] zero, except in SYNC, where [15:0] = drop_count and fields [16:10] are zero.
- Two-word records (header then second word):
  - SYNC: second word = instr_pc. Then clear drop_count and sync_pending.
  - BKPT: second word = instr_pc.
  - BRANCH: second word = branch_target.
  - All three clear seq_count after the header captures it.
- Sequential record: seq_count += 1.
  - On reaching 255, push a 1-word SEQ header (count 255) and clear seq_count to 0 in the same cycle.
  - If that push is dropped, seq_count still clears to 0.
- flush:
  - Applies on clk__enable with seq_count!=0 and no record pushed this cycle.
  - Pushes a SEQ header with the current count and clears seq_count.
  - A flush colliding with a pushed record is absorbed, because the record already carries the count.
- Space rule:
  - A record of N words is written only if free space ≥ N.
  - free = depth − level + (pop this cycle ? 1 : 0).
  - Both words of a record are written in the same cycle, so the FIFO has two write ports and one read port.
  - Words never split; a record is all-or-nothing.
- Drop:
  - drop_count saturates at 0xFFFF; overflow_sticky is set; sync_pending is set.
  - The dropped instruction and the preceding seq_count are lost; seq_count resets to 0.
  - While sync_pending, every later record is a SYNC attempt needing 2 words.
- Falling trace_enable:
  - Sets sync_pending.
  - Does not emit the count; software uses flush first.
- Reset mid-packet: FIFO contents are discarded; the stream restarts with a SYNC carrying drop_count=0.
- Latency:
  - Record words are visible at pkt_data no earlier than the next clk edge.
  - An empty FIFO shows its first written word one cycle after the write.
- Pointers wrap modulo depth; level is one bit wider to distinguish full from empty.
- Assertion: no FIFO write when the space rule is violated, and no pop when empty.

Decomposition:
- Shared package riscv_i32_trace_pack_types holds:
  - packet type constants SYNC/SEQ/BRANCH/BKPT;
  - header field positions;
  - the seq_count saturation constant 255.
- Trace bus struct comes from the existing trace type package.
- One sub-module: riscv_i32_trace_pack_fifo, a 2-write/1-read synchronous FIFO parameterised by FIFO_LOG2 with level output.

Test Plan:
- Reset, then one valid sequential instruction at pc 0x1000, mode 3 -> words 0x00060000, 0x00001000; then 3 sequential instrs, taken branch to 0x2000 -> 0x20360000, 0x00002000.
- 255 sequential instrs after sync -> single word 0x1FF60000, seq_count back to 0; a 256th instr then flush -> 0x10160000.
- bkpt_valid reason 5 together with branch_taken at pc 0x3000 -> BKPT 0x30061400, 0x00003000; branch target not emitted.
- Hold pkt_ready=0 with depth 16, run branches until full, drop 3 records, release ready -> overflow_sticky=1; first new record is SYNC with [15:0]=3 and the current pc.
- Full FIFO with simultaneous pop and a 2-word record -> record dropped (free=1); with free=2 via pop -> accepted, level unchanged+1.
- Assert reset_n low mid-stream with FIFO level 7 -> pkt_valid=0, level=0 immediately (async); next instruction yields SYNC with drop_count 0.
